// File: rtl/pc_sequencer.sv
// Fetch/PC controller: owns the PC, runs the instruction-memory handshake and counts retired instructions.
// Optional fetch watchdog is built only when PC_SEQ_TIMEOUT_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    input  logic        stall,
    input  logic        trap,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        misalign,
    output logic        fetch_timeout,
    output logic [31:0] instret,
    output logic [1:0]  dbg_state
);

    // Handshake: imem_req stays high and imem_addr stays stable in FETCH until a cycle with
    // imem_ack high; imem_rdata is captured on that same edge.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic        misalign_q, misalign_d;
    logic        fetch_timeout_q, fetch_timeout_d;

`ifdef PC_SEQ_TIMEOUT_EN
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        tmo_pend_q, tmo_pend_d;
    logic        tmo_hit;
`endif

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        instret_d       = instret_q;
        misalign_d      = 1'b0;
        fetch_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    state_d   = ST_FETCH;
                    instret_d = instret_q + 32'd1;
                    // Only computed redirect targets are alignment-checked.
                    if (trap) begin
                        pc_d = TRAP_VECTOR;
                    end else if (jump) begin
                        if (jump_target[1:0] != 2'b00) begin
                            pc_d       = TRAP_VECTOR;
                            misalign_d = 1'b1;
                        end else begin
                            pc_d = jump_target;
                        end
                    end else if (branch_taken) begin
                        if (branch_target[1:0] != 2'b00) begin
                            pc_d       = TRAP_VECTOR;
                            misalign_d = 1'b1;
                        end else begin
                            pc_d = branch_target;
                        end
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef PC_SEQ_TIMEOUT_EN
        // Counter is zero in the first FETCH cycle and counts unacknowledged FETCH cycles.
        wait_cnt_d = (state_q == ST_FETCH) ? wait_cnt_q + 8'd1 : 8'd0;
        tmo_hit    = (state_q == ST_FETCH) && !imem_ack &&
                     (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
        tmo_pend_d = tmo_pend_q;
        if (tmo_hit) begin
            state_d    = ST_IDLE;
            pc_d       = TRAP_VECTOR;
            tmo_pend_d = 1'b1;
        end else if (state_q == ST_IDLE) begin
            tmo_pend_d = 1'b0;
        end
        // Pulse lands in the FETCH cycle that follows the IDLE gap.
        fetch_timeout_d = (state_q == ST_IDLE) && tmo_pend_q;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            pc_q            <= RESET_VECTOR;
            instr_q         <= NOP;
            instret_q       <= 32'd0;
            misalign_q      <= 1'b0;
            fetch_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            instret_q       <= instret_d;
            misalign_q      <= misalign_d;
            fetch_timeout_q <= fetch_timeout_d;
        end
    end

`ifdef PC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= 8'd0;
            tmo_pend_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            tmo_pend_q <= tmo_pend_d;
        end
    end
`endif

    assign imem_req      = (state_q == ST_FETCH);
    assign imem_addr     = pc_q;
    assign pc_out        = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = (state_q == ST_EXEC);
    assign misalign      = misalign_q;
    assign fetch_timeout = fetch_timeout_q;
    assign instret       = instret_q;
    assign dbg_state     = state_q;

endmodule
